// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// FSM encoding, port indices and default bus geometry.
package sram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int WORD_WIDTH_DEF = 8;
  localparam int TIMEOUT_DEF    = 15;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the SRAM controller.
// slave = arbiter view, master = requesters plus controller view.
interface sram_port_arbiter_if
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int WORD_WIDTH = WORD_WIDTH_DEF
);

  logic                  req0;
  logic                  req1;
  logic                  wr0;
  logic                  wr1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [WORD_WIDTH-1:0] wdata0;
  logic [WORD_WIDTH-1:0] wdata1;
  logic                  ack0;
  logic                  ack1;
  logic                  err0;
  logic                  err1;
  logic [WORD_WIDTH-1:0] rdata;
  logic [ADDR_WIDTH-1:0] m_haddr;
  logic [WORD_WIDTH-1:0] m_hwdata;
  logic                  m_hwrite;
  logic [WORD_WIDTH-1:0] m_hrdata;
  logic                  m_hready;

  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
    input  m_hrdata, m_hready,
    output ack0, ack1, err0, err1, rdata,
    output m_haddr, m_hwdata, m_hwrite
  );

  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
    output m_hrdata, m_hready,
    input  ack0, ack1, err0, err1, rdata,
    input  m_haddr, m_hwdata, m_hwrite
  );

endinterface

// File: rtl/sram_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that was not served last.
module sram_rr_pick2
  import sram_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_idx,
  output logic       gnt_vld
);

  always_comb begin
    gnt_vld = |req;
    gnt_idx = PORT_CPU;
    if (req == 2'b11) begin
      gnt_idx = ~last_gnt;
    end else if (req[1]) begin
      gnt_idx = PORT_DMA;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM controller port between CPU (port 0) and DMA (port 1).
// Sequences IDLE -> ISSUE -> WAIT -> DONE with a WAIT timeout that aborts with err.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic               hclk,
  input  logic               hreset,
  sram_port_arbiter_if.slave bus
);

  localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT - 1);

  arb_state_t            r_state;
  logic                  r_last_gnt;
  logic                  r_gnt_idx;
  logic [3:0]            r_wait_cnt;
  logic [1:0]            r_ack;
  logic [1:0]            r_err;
  logic [ADDR_WIDTH-1:0] r_haddr;
  logic [WORD_WIDTH-1:0] r_hwdata;
  logic                  r_hwrite;
  logic [WORD_WIDTH-1:0] r_rdata;

  logic                  w_gnt_idx;
  logic                  w_gnt_vld;
  logic                  w_sel_wr;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [WORD_WIDTH-1:0] w_sel_wdata;

  sram_rr_pick2 u_pick (
    .req      ({bus.req1, bus.req0}),
    .last_gnt (r_last_gnt),
    .gnt_idx  (w_gnt_idx),
    .gnt_vld  (w_gnt_vld)
  );

  assign w_sel_wr    = w_gnt_idx ? bus.wr1    : bus.wr0;
  assign w_sel_addr  = w_gnt_idx ? bus.addr1  : bus.addr0;
  assign w_sel_wdata = w_gnt_idx ? bus.wdata1 : bus.wdata0;

  // ack is registered on the WAIT exit edge, so it is high during the DONE cycle
  // together with the captured rdata; err is high in the IDLE cycle after an abort.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= PORT_DMA;
      r_gnt_idx  <= PORT_CPU;
      r_wait_cnt <= '0;
      r_ack      <= '0;
      r_err      <= '0;
      r_haddr    <= '0;
      r_hwdata   <= '0;
      r_hwrite   <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_ack <= '0;
      r_err <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_vld) begin
            r_gnt_idx <= w_gnt_idx;
            r_haddr   <= w_sel_addr;
            r_hwdata  <= w_sel_wdata;
            r_hwrite  <= w_sel_wr;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 4'd1;
          // hready is blanked in the first WAIT cycle (controller deassert latency)
          if (bus.m_hready && (r_wait_cnt != 4'd0)) begin
            r_ack[r_gnt_idx] <= 1'b1;
            r_last_gnt       <= r_gnt_idx;
            r_state          <= ST_DONE;
            if (!r_hwrite) begin
              r_rdata <= bus.m_hrdata;
            end
          end else if (r_wait_cnt == TIMEOUT_LAST) begin
            r_err[r_gnt_idx] <= 1'b1;
            r_last_gnt       <= r_gnt_idx;
            r_state          <= ST_IDLE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ack0     = r_ack[0];
  assign bus.ack1     = r_ack[1];
  assign bus.err0     = r_err[0];
  assign bus.err1     = r_err[1];
  assign bus.rdata    = r_rdata;
  assign bus.m_haddr  = r_haddr;
  assign bus.m_hwdata = r_hwdata;
  assign bus.m_hwrite = r_hwrite;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: transaction-age model checked every cycle
// plus literal expectations for latency, data, grant order, timeout and reset.
module tb_sram_port_arbiter;
  import sram_port_arbiter_pkg::*;

  logic hclk;
  logic hreset;
  logic hready_v;
  logic [7:0] mem [16];

  int checks = 0;
  int errors = 0;

  sram_port_arbiter_if #(.ADDR_WIDTH(4), .WORD_WIDTH(8)) bus ();

  sram_port_arbiter #(.ADDR_WIDTH(4), .WORD_WIDTH(8), .TIMEOUT(15)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  assign bus.m_hready = hready_v;
  assign bus.m_hrdata = mem[bus.m_haddr];

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  logic [1:0] exp_ack = '0;
  logic [1:0] exp_err = '0;
  logic [7:0] exp_rdata = '0;
  logic [3:0] exp_haddr = '0;
  logic [7:0] exp_hwdata = '0;
  logic       exp_hwrite = 1'b0;
  bit         m_busy = 0;
  bit         m_done = 0;
  int         m_age = 0;
  int         m_port = 0;
  int         m_last = 1;

  initial begin : model_cmp
    @(posedge hclk);
    forever begin
      @(negedge hclk);
      check("cyc_ack0",   32'(bus.ack0),     32'(exp_ack[0]));
      check("cyc_ack1",   32'(bus.ack1),     32'(exp_ack[1]));
      check("cyc_err0",   32'(bus.err0),     32'(exp_err[0]));
      check("cyc_err1",   32'(bus.err1),     32'(exp_err[1]));
      check("cyc_rdata",  32'(bus.rdata),    32'(exp_rdata));
      check("cyc_haddr",  32'(bus.m_haddr),  32'(exp_haddr));
      check("cyc_hwdata", 32'(bus.m_hwdata), 32'(exp_hwdata));
      check("cyc_hwrite", 32'(bus.m_hwrite), 32'(exp_hwrite));
      // predict what the outputs must be after the coming edge
      exp_ack = '0;
      exp_err = '0;
      if (hreset) begin
        m_busy = 0; m_done = 0; m_last = 1;
        exp_rdata = '0; exp_haddr = '0; exp_hwdata = '0; exp_hwrite = 1'b0;
      end else if (!m_busy) begin
        if (bus.req0 || bus.req1) begin
          if (bus.req0 && bus.req1) m_port = 1 - m_last;
          else m_port = bus.req1 ? 1 : 0;
          exp_haddr  = (m_port == 1) ? bus.addr1  : bus.addr0;
          exp_hwdata = (m_port == 1) ? bus.wdata1 : bus.wdata0;
          exp_hwrite = (m_port == 1) ? bus.wr1    : bus.wr0;
          m_busy = 1; m_done = 0; m_age = 0;
        end
      end else if (m_done) begin
        m_busy = 0;
      end else begin
        // age 1 = issue cycle, age 2 = first wait cycle (hready blanked)
        m_age++;
        if (m_age >= 3 && hready_v) begin
          exp_ack[m_port] = 1'b1;
          m_done = 1;
          m_last = m_port;
          if (exp_hwrite) mem[exp_haddr] = exp_hwdata;
          else exp_rdata = mem[exp_haddr];
        end else if (m_age - 2 == TIMEOUT_DEF - 1) begin
          exp_err[m_port] = 1'b1;
          m_busy = 0;
          m_last = m_port;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic run_xfer(input int port, input logic wr, input logic [3:0] addr,
                          input logic [7:0] wd, input int low, input int maxc,
                          output int lat, output bit got_ack, output bit got_err);
    tick();
    hready_v = (low == 0);
    if (port == 0) begin
      bus.req0 = 1'b1; bus.wr0 = wr; bus.addr0 = addr; bus.wdata0 = wd;
    end else begin
      bus.req1 = 1'b1; bus.wr1 = wr; bus.addr1 = addr; bus.wdata1 = wd;
    end
    lat = 0; got_ack = 0; got_err = 0;
    for (int i = 1; i <= maxc && !got_ack && !got_err; i++) begin
      tick();
      if (i == 2 + low) hready_v = 1'b1;
      got_ack = (port == 0) ? bus.ack0 : bus.ack1;
      got_err = (port == 0) ? bus.err0 : bus.err1;
      if (got_ack || got_err) begin
        lat = i;
        bus.req0 = (port == 0) ? 1'b0 : bus.req0;
        bus.req1 = (port == 1) ? 1'b0 : bus.req1;
      end
    end
    if (!got_ack && !got_err) begin
      check("xfer_bound", 32'(maxc), 32'(0));
      bus.req0 = 1'b0; bus.req1 = 1'b0;
    end
    $display("xfer port=%0d wr=%0d addr=%0h lat=%0d ack=%0d err=%0d rdata=%02h",
             port, wr, addr, lat, got_ack, got_err, bus.rdata);
  endtask

  int order_q[$];

  task automatic contend(input int n, input int maxc);
    tick();
    hready_v = 1'b1;
    bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.addr0 = 4'h5; bus.wdata0 = 8'h11;
    bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = 4'h5;
    order_q.delete();
    for (int i = 0; i < maxc && order_q.size() < n; i++) begin
      tick();
      if (bus.ack0 || bus.ack1 || bus.err0 || bus.err1) begin
        check("one_pulse", 32'($countones({bus.ack0, bus.ack1, bus.err0, bus.err1})), 32'(1));
        if (bus.ack0) order_q.push_back(0);
        else if (bus.ack1) order_q.push_back(1);
        $display("xfer contended port=%0d rdata=%02h", bus.ack1 ? 1 : 0, bus.rdata);
        if (order_q.size() == n) begin
          bus.req0 = 1'b0; bus.req1 = 1'b0;
        end
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    check("contend_count", 32'(order_q.size()), 32'(n));
  endtask

  task automatic do_reset();
    hreset = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();
    tick();
    hreset = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  int lat;
  bit ga, ge;
  int exp_order[4];

  initial begin : stim
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    hreset = 1'b1; hready_v = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.wr0 = 1'b0; bus.wr1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    repeat (2) @(posedge hclk);
    #1;
    check("rst_ack0", 32'(bus.ack0), 32'(0));
    check("rst_haddr", 32'(bus.m_haddr), 32'(0));
    hreset = 1'b0;

    // single write, hready low in the first wait cycle
    run_xfer(0, 1'b1, 4'h3, 8'hA5, 1, 40, lat, ga, ge);
    check("wr_ack", 32'(ga), 32'(1));
    check("wr_lat", 32'(lat), 32'(4));
    check("wr_haddr", 32'(bus.m_haddr), 32'h3);
    check("wr_hwdata", 32'(bus.m_hwdata), 32'hA5);
    check("wr_hwrite", 32'(bus.m_hwrite), 32'(1));
    check("wr_rdata_kept", 32'(bus.rdata), 32'h00);

    // single read with hready high throughout: blanking forces latency 4
    run_xfer(1, 1'b0, 4'h3, 8'h00, 0, 40, lat, ga, ge);
    check("rd_ack", 32'(ga), 32'(1));
    check("rd_lat_blank", 32'(lat), 32'(4));
    check("rd_rdata", 32'(bus.rdata), 32'hA5);
    tick(); tick();
    check("rd_rdata_hold", 32'(bus.rdata), 32'hA5);

    // contention from reset: 0,1,0,1
    do_reset();
    contend(4, 60);
    exp_order = '{0, 1, 0, 1};
    for (int k = 0; k < 4; k++)
      check($sformatf("rr_order%0d", k), 32'((k < order_q.size()) ? order_q[k] : 99), 32'(exp_order[k]));
    check("rr_rdata", 32'(bus.rdata), 32'h11);

    // timeout with hready stuck low, then a normal port-1 read
    run_xfer(0, 1'b0, 4'h7, 8'h00, 255, 40, lat, ga, ge);
    check("to_err", 32'(ge), 32'(1));
    check("to_no_ack", 32'(ga), 32'(0));
    check("to_lat", 32'(lat), 32'(17));
    run_xfer(1, 1'b0, 4'h3, 8'h00, 0, 40, lat, ga, ge);
    check("after_to_ack", 32'(ga), 32'(1));
    check("after_to_lat", 32'(lat), 32'(4));

    // reset in the middle of a port-1 wait after port 0 was served last
    run_xfer(0, 1'b1, 4'h9, 8'h3C, 0, 40, lat, ga, ge);
    check("pre_rst_ack", 32'(ga), 32'(1));
    tick();
    hready_v = 1'b0;
    bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = 4'h9;
    repeat (3) tick();
    hreset = 1'b1; bus.req1 = 1'b0;
    tick();
    hreset = 1'b0;
    check("mid_rst_ack1", 32'(bus.ack1), 32'(0));
    check("mid_rst_err1", 32'(bus.err1), 32'(0));
    check("mid_rst_haddr", 32'(bus.m_haddr), 32'(0));
    check("mid_rst_hwdata", 32'(bus.m_hwdata), 32'(0));
    check("mid_rst_rdata", 32'(bus.rdata), 32'(0));
    $display("xfer port=1 aborted by reset");
    repeat (4) tick();
    contend(2, 40);
    check("post_rst_first", 32'((order_q.size() > 0) ? order_q[0] : 99), 32'(0));
    check("post_rst_second", 32'((order_q.size() > 1) ? order_q[1] : 99), 32'(1));
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
